// File: rtl/core_sequencer_if.sv
// Instruction- and data-memory handshake bundle between the sequencer and memory.
// master = sequencer side, slave = memory side.
interface core_sequencer_if;
  logic        imem_req;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_gnt;
  logic        dmem_rvalid;

  modport master (
    output imem_req,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata,
    output dmem_req,
    output dmem_we,
    input  dmem_gnt,
    input  dmem_rvalid
  );

  modport slave (
    input  imem_req,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata,
    input  dmem_req,
    input  dmem_we,
    output dmem_gnt,
    output dmem_rvalid
  );
endinterface

// File: rtl/core_sequencer.sv
// Multi-cycle RV32I control sequencer: owns PC/IR, steps fetch-decode-execute-mem-writeback,
// drives the memory handshakes and halts on an illegal opcode or a memory timeout.
module core_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 255,
  parameter int          CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              run,
  input  logic [31:0]       next_pc,
  output logic [31:0]       pc,
  output logic [31:0]       ir,
  input  logic              dec_reg_wr_en,
  input  logic              dec_ram_wr_en,
  input  logic              dec_reg_write_data_src,
  output logic              rf_wr_en,
  output logic              halted,
  output logic [1:0]        err,
  output logic [CNT_W-1:0]  instret,
  output logic [2:0]        state,
  core_sequencer_if.master  mem
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    FWAIT  = 3'd2,
    DECODE = 3'd3,
    EXEC   = 3'd4,
    MEM    = 3'd5,
    MWAIT  = 3'd6,
    WB     = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_ILLOP = 2'd1,
    ERR_IMEM  = 2'd2,
    ERR_DMEM  = 2'd3
  } err_e;

  // The cycle that sees this count is the last one a transaction may occupy.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_e             state_q,   state_d;
  logic [31:0]        pc_q,      pc_d;
  logic [31:0]        ir_q,      ir_d;
  logic [CNT_W-1:0]   instret_q, instret_d;
  logic               halted_q,  halted_d;
  err_e               err_q,     err_d;
  logic [15:0]        tmoCnt_q,  tmoCnt_d;

  logic               opLegal;
  logic               tmoLast;

  function automatic logic isLegalOp(input logic [6:0] op);
    case (op)
      7'b0110011, 7'b0010011, 7'b0000011,
      7'b0100011, 7'b1100011, 7'b1101111,
      7'b1100111, 7'b0110111, 7'b0010111: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  assign opLegal = isLegalOp(ir_q[6:0]);
  assign tmoLast = (tmoCnt_q == TMO_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      instret_q <= '0;
      halted_q  <= 1'b0;
      err_q     <= ERR_NONE;
      tmoCnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      instret_q <= instret_d;
      halted_q  <= halted_d;
      err_q     <= err_d;
      tmoCnt_q  <= tmoCnt_d;
    end
  end

  // The timeout count defaults to zero, which clears it on entry to FETCH and MEM.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    instret_d = instret_q;
    halted_d  = halted_q;
    err_d     = err_q;
    tmoCnt_d  = '0;

    case (state_q)
      IDLE: begin
        if (run && !halted_q) begin
          state_d = FETCH;
        end
      end

      FETCH: begin
        tmoCnt_d = tmoCnt_q + 16'd1;
        if (tmoLast) begin
          err_d    = ERR_IMEM;
          halted_d = 1'b1;
          state_d  = IDLE;
        end else if (mem.imem_gnt) begin
          state_d = FWAIT;
        end
      end

      FWAIT: begin
        tmoCnt_d = tmoCnt_q + 16'd1;
        if (mem.imem_rvalid) begin
          ir_d    = mem.imem_rdata;
          state_d = DECODE;
        end else if (tmoLast) begin
          err_d    = ERR_IMEM;
          halted_d = 1'b1;
          state_d  = IDLE;
        end
      end

      DECODE: begin
        if (opLegal) begin
          state_d = EXEC;
        end else begin
          err_d    = ERR_ILLOP;
          halted_d = 1'b1;
          state_d  = IDLE;
        end
      end

      EXEC: begin
        if (dec_reg_write_data_src || dec_ram_wr_en) begin
          state_d = MEM;
        end else begin
          state_d = WB;
        end
      end

      MEM: begin
        tmoCnt_d = tmoCnt_q + 16'd1;
        if (tmoLast) begin
          err_d    = ERR_DMEM;
          halted_d = 1'b1;
          state_d  = IDLE;
        end else if (mem.dmem_gnt) begin
          state_d = MWAIT;
        end
      end

      MWAIT: begin
        tmoCnt_d = tmoCnt_q + 16'd1;
        if (mem.dmem_rvalid) begin
          state_d = WB;
        end else if (tmoLast) begin
          err_d    = ERR_DMEM;
          halted_d = 1'b1;
          state_d  = IDLE;
        end
      end

      WB: begin
        pc_d      = next_pc;
        instret_d = instret_q + CNT_W'(1);
        state_d   = run ? FETCH : IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Requests decode straight from state so an async reset drops them at once.
  assign mem.imem_req = (state_q == FETCH);
  assign mem.dmem_req = (state_q == MEM);
  assign mem.dmem_we  = (state_q == MEM) && dec_ram_wr_en;
  assign rf_wr_en     = (state_q == WB)  && dec_reg_wr_en;

  assign pc      = pc_q;
  assign ir      = ir_q;
  assign instret = instret_q;
  assign halted  = halted_q;
  assign err     = err_q;
  assign state   = state_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed self-checking bench for core_sequencer: normal instructions, memory stalls,
// illegal opcode, fetch/data timeouts, run drop, async reset mid-transaction and instret wrap.
module tb_core_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          TIMEOUT  = 8;
  localparam int          CNT_W    = 4;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_LW   = 32'h0000A103;
  localparam logic [31:0] I_SW   = 32'h0020A023;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_LUI  = 32'h000012B7;
  localparam logic [31:0] I_ILL  = 32'hFFFFFFFF;

  logic              clk = 1'b0;
  logic              rstn;
  logic              run;
  logic [31:0]       nextPc;
  logic [31:0]       pc;
  logic [31:0]       ir;
  logic              decRegWrEn;
  logic              decRamWrEn;
  logic              decSrc;
  logic              rfWrEn;
  logic              halted;
  logic [1:0]        err;
  logic [CNT_W-1:0]  instret;
  logic [2:0]        state;

  logic [CNT_W-1:0]  expInstret;
  int                nChecks = 0;
  int                nFail   = 0;

  core_sequencer_if memIf ();

  core_sequencer #(
    .RESET_PC (RESET_PC),
    .TIMEOUT  (TIMEOUT),
    .CNT_W    (CNT_W)
  ) dut (
    .clk                    (clk),
    .rstn                   (rstn),
    .run                    (run),
    .next_pc                (nextPc),
    .pc                     (pc),
    .ir                     (ir),
    .dec_reg_wr_en          (decRegWrEn),
    .dec_ram_wr_en          (decRamWrEn),
    .dec_reg_write_data_src (decSrc),
    .rf_wr_en               (rfWrEn),
    .halted                 (halted),
    .err                    (err),
    .instret                (instret),
    .state                  (state),
    .mem                    (memIf)
  );

  always #5 clk = ~clk;

  // Hard stop in case the sequence never completes.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed no completion, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nChecks++;
    assert (observed === expected) else begin
      nFail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic clearMem();
    memIf.imem_gnt    = 1'b0;
    memIf.imem_rvalid = 1'b0;
    memIf.dmem_gnt    = 1'b0;
    memIf.dmem_rvalid = 1'b0;
  endtask

  // Fetch one word with immediate grant and rvalid; starts in FETCH, ends in DECODE.
  task automatic fetchWord(input logic [31:0] word);
    memIf.imem_rdata = word;
    memIf.imem_gnt   = 1'b1;
    tick();
    memIf.imem_gnt    = 1'b0;
    memIf.imem_rvalid = 1'b1;
    tick();
    memIf.imem_rvalid = 1'b0;
  endtask

  // Runs one instruction from its FETCH cycle for expTotal cycles with a memory model
  // that grants after a given number of request cycles and answers a given number later.
  task automatic applyStimulus(
    input string       tag,
    input logic [31:0] instr,
    input logic        regWr,
    input logic        ramWr,
    input logic        isLoad,
    input int          iGntWait,
    input int          iRvWait,
    input int          dGntWait,
    input int          dRvWait,
    input logic [31:0] newPc,
    input int          dropRunAt,
    input int          abortAt,
    input int          expTotal,
    input int          expIReq,
    input int          expDReq,
    input int          expWe,
    input int          expRf
  );
    int iCnt = 0, iK = 0, dCnt = 0, dK = 0;
    bit iGr = 1'b0, dGr = 1'b0;
    int nIReq = 0, nDReq = 0, nWe = 0, nRf = 0, rfAt = 0;
    decRegWrEn       = regWr;
    decRamWrEn       = ramWr;
    decSrc           = isLoad;
    nextPc           = newPc;
    memIf.imem_rdata = instr;
    for (int c = 1; c <= expTotal; c++) begin
      clearMem();
      if (iGr) begin
        iK++;
        if (iK == iRvWait) begin
          memIf.imem_rvalid = 1'b1;
          iGr = 1'b0;
        end
      end else if (memIf.imem_req) begin
        if (iCnt == iGntWait) begin
          memIf.imem_gnt = 1'b1;
          iGr = 1'b1;
          iK  = 0;
        end
        iCnt++;
      end
      if (dGr) begin
        dK++;
        if (dK == dRvWait) begin
          memIf.dmem_rvalid = 1'b1;
          dGr = 1'b0;
        end
      end else if (memIf.dmem_req) begin
        if (dCnt == dGntWait) begin
          memIf.dmem_gnt = 1'b1;
          dGr = 1'b1;
          dK  = 0;
        end
        dCnt++;
      end
      if (c == dropRunAt) run = 1'b0;
      settle();
      if (c == abortAt) begin
        rstn = 1'b0;
        clearMem();
        settle();
        return;
      end
      if (memIf.imem_req) nIReq++;
      if (memIf.dmem_req) nDReq++;
      if (memIf.dmem_we)  nWe++;
      if (rfWrEn) begin
        nRf++;
        rfAt = c;
      end
      if (c == expTotal) checkOutput({tag, "-wbState"}, 32'(state), 32'd7);
      tick();
    end
    clearMem();
    expInstret = expInstret + 1'b1;
    checkOutput({tag, "-imemReqCycles"}, 32'(nIReq), 32'(expIReq));
    checkOutput({tag, "-dmemReqCycles"}, 32'(nDReq), 32'(expDReq));
    checkOutput({tag, "-dmemWeCycles"},  32'(nWe),   32'(expWe));
    checkOutput({tag, "-rfPulses"},      32'(nRf),   32'(expRf));
    if (expRf != 0) checkOutput({tag, "-rfCycle"}, 32'(rfAt), 32'(expTotal));
    checkOutput({tag, "-pc"},      pc,           newPc);
    checkOutput({tag, "-instret"}, 32'(instret), 32'(expInstret));
    if (run) checkOutput({tag, "-nextFetch"}, 32'(memIf.imem_req), 32'd1);
    else     checkOutput({tag, "-idle"},      32'(state),          32'd0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "-pc"},       pc,                       RESET_PC);
    checkOutput({tag, "-ir"},       ir,                       32'd0);
    checkOutput({tag, "-state"},    32'(state),               32'd0);
    checkOutput({tag, "-instret"},  32'(instret),             32'd0);
    checkOutput({tag, "-halted"},   32'(halted),              32'd0);
    checkOutput({tag, "-err"},      32'(err),                 32'd0);
    checkOutput({tag, "-imemReq"},  32'(memIf.imem_req),      32'd0);
    checkOutput({tag, "-dmemReq"},  32'(memIf.dmem_req),      32'd0);
    checkOutput({tag, "-dmemWe"},   32'(memIf.dmem_we),       32'd0);
    checkOutput({tag, "-rfWrEn"},   32'(rfWrEn),              32'd0);
  endtask

  initial begin
    int n;
    rstn = 1'b0;  run = 1'b0;  nextPc = '0;
    decRegWrEn = 1'b1;  decRamWrEn = 1'b1;  decSrc = 1'b0;
    memIf.imem_rdata = '0;
    clearMem();
    expInstret = '0;

    // Reset values with decoder enables high to prove the strobes are gated.
    #12;
    checkResetValues("reset");
    rstn = 1'b1;
    tick();
    checkOutput("idleNoRun", 32'(state), 32'd0);
    decRamWrEn = 1'b0;
    run = 1'b1;
    tick();
    checkOutput("fetchEntry", 32'(state), 32'd1);

    applyStimulus("add",   I_ADD, 1'b1, 1'b0, 1'b0, 0, 1, 0, 1, 32'h4,  0, 0,  5, 1, 0, 0, 1);
    applyStimulus("load",  I_LW,  1'b1, 1'b0, 1'b1, 0, 1, 3, 2, 32'h8,  0, 0, 11, 1, 4, 0, 1);
    applyStimulus("store", I_SW,  1'b0, 1'b1, 1'b0, 0, 1, 0, 1, 32'hC,  0, 0,  7, 1, 1, 1, 0);
    applyStimulus("beqSlowFetch", I_BEQ, 1'b0, 1'b0, 1'b0, 2, 3, 0, 1, 32'h40, 0, 0, 9, 3, 0, 0, 0);
    applyStimulus("fetchAtLimit", I_LUI, 1'b1, 1'b0, 1'b0, 6, 1, 0, 1, 32'h44, 0, 0, 11, 7, 0, 0, 1);
    applyStimulus("runDrop", I_ADD, 1'b1, 1'b0, 1'b0, 0, 1, 0, 1, 32'h48, 4, 0, 5, 1, 0, 0, 1);
    tick();
    tick();
    checkOutput("runDrop-staysIdle", 32'(state), 32'd0);
    checkOutput("runDrop-noReq",     32'(memIf.imem_req), 32'd0);

    // Illegal opcode halts from DECODE and stays parked until reset.
    run = 1'b1;
    tick();
    fetchWord(I_ILL);
    checkOutput("illegal-inDecode", 32'(state),  32'd3);
    checkOutput("illegal-notYet",   32'(halted), 32'd0);
    tick();
    checkOutput("illegal-halted",  32'(halted),  32'd1);
    checkOutput("illegal-err",     32'(err),     32'd1);
    checkOutput("illegal-state",   32'(state),   32'd0);
    checkOutput("illegal-pc",      pc,           32'h48);
    checkOutput("illegal-instret", 32'(instret), 32'(expInstret));
    checkOutput("illegal-ir",      ir,           I_ILL);
    n = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (memIf.imem_req) n++;
    end
    checkOutput("illegal-noRefetch", 32'(n), 32'd0);
    rstn = 1'b0;
    settle();
    checkResetValues("haltClear");
    expInstret = '0;
    rstn = 1'b1;

    // Instruction fetch never granted.
    tick();
    n = 0;
    for (int c = 0; c < 20 && !halted; c++) begin
      if (memIf.imem_req) n++;
      tick();
    end
    checkOutput("imemTmo-reqCycles", 32'(n),              32'd8);
    checkOutput("imemTmo-halted",    32'(halted),         32'd1);
    checkOutput("imemTmo-err",       32'(err),            32'd2);
    checkOutput("imemTmo-reqLow",    32'(memIf.imem_req), 32'd0);
    rstn = 1'b0;
    settle();
    rstn = 1'b1;

    // Load whose data request is never granted.
    tick();
    decRegWrEn = 1'b1;  decRamWrEn = 1'b0;  decSrc = 1'b1;
    fetchWord(I_LW);
    tick();
    tick();
    n = 0;
    for (int c = 0; c < 20 && !halted; c++) begin
      if (memIf.dmem_req) n++;
      tick();
    end
    checkOutput("dmemTmo-reqCycles", 32'(n),              32'd8);
    checkOutput("dmemTmo-halted",    32'(halted),         32'd1);
    checkOutput("dmemTmo-err",       32'(err),            32'd3);
    checkOutput("dmemTmo-reqLow",    32'(memIf.dmem_req), 32'd0);
    checkOutput("dmemTmo-instret",   32'(instret),        32'd0);
    rstn = 1'b0;
    settle();
    rstn = 1'b1;

    // Asynchronous reset while the data request is pending, then while waiting for rvalid.
    tick();
    applyStimulus("rstInMem", I_LW, 1'b1, 1'b0, 1'b1, 0, 1, 3, 2, 32'h50, 0, 6, 11, 1, 4, 0, 1);
    checkResetValues("rstInMem");
    rstn = 1'b1;
    tick();
    applyStimulus("rstInMwait", I_LW, 1'b1, 1'b0, 1'b1, 0, 1, 0, 4, 32'h50, 0, 6, 11, 1, 1, 0, 1);
    checkResetValues("rstInMwait");
    rstn = 1'b1;

    // Sixteen instructions wrap the 4-bit retired counter back to zero.
    tick();
    for (int i = 0; i < 16; i++) begin
      applyStimulus("wrap", I_ADD, 1'b1, 1'b0, 1'b0, 0, 1, 0, 1, 32'(4 * (i + 1)), 0, 0, 5, 1, 0, 0, 1);
    end
    checkOutput("wrap-instretZero", 32'(instret), 32'd0);
    checkOutput("wrap-pc",          pc,           32'd64);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
